char_box_locator: RTL and testbench

Finds the bounding box of one licence-plate character in a binarised pixel stream and publishes it as `char_up/down/left/right` for the downstream digit feature scanner. During each frame it accumulates row statistics and a per-column occupancy map inside a programmable plate window. In vertical blanking, a small FSM scans the column map to pick the `char_idx`-th character run. Bounds are updated only during blanking, so they stay constant while the next frame is active.

---
 rtl/char_box_locator_pkg.sv | 19 +
 rtl/char_col_map.sv | 28 ++
 rtl/char_box_locator.sv | 207 ++++++++++++++++++++
 tb/tb_char_box_locator.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/char_box_locator_pkg.sv
// Shared types for the plate character locator and its downstream feature scanner.
package char_box_locator_pkg;

   localparam int COORD_W = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] up;
      logic [COORD_W-1:0] down;
      logic [COORD_W-1:0] left;
      logic [COORD_W-1:0] right;
   } char_box_t;

endpackage

// File: rtl/char_col_map.sv
// Per-column occupancy bits: set while the frame streams, read-and-clear during the scan.
module char_col_map #(
   parameter int MAX_W = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_bit
);

   logic [MAX_W-1:0] col_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_hit <= '0;
      end else begin
         if (rd_en)  col_hit[rd_addr]  <= 1'b0;
         if (set_en) col_hit[set_addr] <= 1'b1;
      end
   end

   assign rd_bit = col_hit[rd_addr];

endmodule

// File: rtl/char_box_locator.sv
// Locates the char_idx-th character box inside the plate window; bounds move only in blanking.
module char_box_locator
   import char_box_locator_pkg::*;
#(
   parameter int MAX_W      = 256,
   parameter int ROW_MIN    = 3,
   parameter int MIN_CHAR_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_vs,
   input  logic               i_de,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic               i_th,
   input  logic [COORD_W-1:0] win_left,
   input  logic [COORD_W-1:0] win_right,
   input  logic [COORD_W-1:0] win_up,
   input  logic [COORD_W-1:0] win_down,
   input  logic [2:0]         char_idx,
   output logic [COORD_W-1:0] char_up,
   output logic [COORD_W-1:0] char_down,
   output logic [COORD_W-1:0] char_left,
   output logic [COORD_W-1:0] char_right,
   output logic               char_valid
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [COORD_W:0]   MAX_W_C   = (COORD_W+1)'(MAX_W);
   localparam logic [COORD_W:0]   MIN_W_C   = (COORD_W+1)'(MIN_CHAR_W);
   localparam logic [COORD_W:0]   ONE_C     = (COORD_W+1)'(1);
   localparam logic [COORD_W-1:0] ROW_MIN_C = COORD_W'(ROW_MIN);

   state_t             state_q, state_d;
   char_box_t          win_l;
   logic [2:0]         idx_l;
   logic               vs_q, de_q, scan_go;
   logic               vs_rise, vs_fall, de_fall, scan_start;
   logic [COORD_W-1:0] y_q, row_cnt, top, bottom, top_s, bot_s, base;
   logic               top_found, tf_s;
   logic [COORD_W-1:0] x_off;
   logic               in_win, y_in_win;
   logic               scan_en, publish, set_en, rd_bit;
   logic [COORD_W:0]   win_span, n_next, n_cols, col, start_q, start_eff, c_end, run_w;
   logic               in_run, last_col, run_start, run_end, run_ok, captured;
   logic [3:0]         run_cnt;
   logic [COORD_W-1:0] cap_left, cap_right;

   assign vs_rise    = i_vs & ~vs_q;
   assign vs_fall    = ~i_vs & vs_q;
   assign de_fall    = de_q & ~i_de;
   assign scan_start = (state_q == IDLE) & scan_go;
   assign x_off      = i_x - win_l.left;
   assign in_win     = i_de && (i_x >= win_l.left) && (i_x <= win_l.right) &&
                       (i_y >= win_l.up) && (i_y <= win_l.down);
   assign y_in_win   = (y_q >= win_l.up) && (y_q <= win_l.down);

   // Scan length: window width clipped to the map depth, zero for an inverted window.
   always_comb begin
      win_span = {1'b0, win_l.right} - {1'b0, win_l.left} + ONE_C;
      n_next   = '0;
      if (win_l.right < win_l.left) n_next = '0;
      else if (win_span > MAX_W_C)  n_next = MAX_W_C;
      else                          n_next = win_span;
   end

   // Run detection on the column being read this cycle.
   assign last_col  = (col == n_cols - ONE_C);
   assign run_start = rd_bit & ~in_run;
   assign start_eff = run_start ? col : start_q;
   assign run_end   = (in_run & ~rd_bit) | (rd_bit & last_col);
   assign c_end     = rd_bit ? col : col - ONE_C;
   assign run_w     = c_end - start_eff + ONE_C;
   assign run_ok    = run_end && (run_w >= MIN_W_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         de_q      <= 1'b0;
         y_q       <= '0;
         scan_go   <= 1'b0;
         win_l     <= '0;
         idx_l     <= '0;
         row_cnt   <= '0;
         top       <= '0;
         bottom    <= '0;
         top_found <= 1'b0;
      end else begin
         vs_q    <= i_vs;
         de_q    <= i_de;
         scan_go <= vs_fall;
         if (i_de)    y_q   <= i_y;
         if (vs_rise) win_l <= '{up: win_up, down: win_down, left: win_left, right: win_right};
         if (vs_fall) idx_l <= char_idx;
         if (de_fall) row_cnt <= '0;
         else if (in_win && i_th && (row_cnt != '1)) row_cnt <= row_cnt + 1'b1;
         if (vs_rise) begin
            top_found <= 1'b0;
         end else if (de_fall && y_in_win && (row_cnt >= ROW_MIN_C)) begin
            if (!top_found) begin
               top       <= y_q;
               top_found <= 1'b1;
            end
            bottom <= y_q;
         end
      end
   end

   // Row results are snapshotted at scan start so a new frame cannot disturb PUBLISH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_cols    <= '0;
         base      <= '0;
         top_s     <= '0;
         bot_s     <= '0;
         tf_s      <= 1'b0;
         col       <= '0;
         start_q   <= '0;
         in_run    <= 1'b0;
         run_cnt   <= '0;
         captured  <= 1'b0;
         cap_left  <= '0;
         cap_right <= '0;
      end else if (scan_start) begin
         n_cols   <= n_next;
         base     <= win_l.left;
         top_s    <= top;
         bot_s    <= bottom;
         tf_s     <= top_found;
         col      <= '0;
         in_run   <= 1'b0;
         run_cnt  <= '0;
         captured <= 1'b0;
      end else if (scan_en) begin
         col    <= col + ONE_C;
         in_run <= rd_bit & ~last_col;
         if (run_start) start_q <= col;
         if (run_ok) begin
            if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
            if (!captured && (run_cnt == {1'b0, idx_l})) begin
               captured  <= 1'b1;
               cap_left  <= base + start_eff[COORD_W-1:0];
               cap_right <= base + c_end[COORD_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (scan_go) state_d = (n_next == '0) ? PUBLISH : SCAN;
         SCAN:    if (last_col) state_d = PUBLISH;
         PUBLISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      scan_en = 1'b0;
      publish = 1'b0;
      set_en  = 1'b0;
      case (state_q)
         IDLE:    set_en  = in_win & i_th & ({1'b0, x_off} < MAX_W_C);
         SCAN:    scan_en = 1'b1;
         PUBLISH: publish = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_up    <= '0;
         char_down  <= '0;
         char_left  <= '0;
         char_right <= '0;
         char_valid <= 1'b0;
      end else if (publish) begin
         char_valid <= captured & tf_s;
         if (captured && tf_s) begin
            char_up    <= top_s;
            char_down  <= bot_s;
            char_left  <= cap_left;
            char_right <= cap_right;
         end
      end
   end

   char_col_map #(
      .MAX_W (MAX_W),
      .AW    (AW)
   ) u_col_map (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (set_en),
      .set_addr (x_off[AW-1:0]),
      .rd_en    (scan_en),
      .rd_addr  (col[AW-1:0]),
      .rd_bit   (rd_bit)
   );

endmodule

// File: tb/tb_char_box_locator.sv
// Directed frames of licence-plate bars against hand-computed character boxes.
module tb_char_box_locator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_vs, i_de, i_th;
   logic [11:0] i_x, i_y;
   logic [11:0] win_left, win_right, win_up, win_down;
   logic [2:0]  char_idx;
   logic [11:0] char_up, char_down, char_left, char_right;
   logic        char_valid;

   int errors = 0;
   int checks = 0;
   logic [48:0] exp_q[$];
   logic [48:0] model_box;

   char_box_locator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_vs       (i_vs),
      .i_de       (i_de),
      .i_x        (i_x),
      .i_y        (i_y),
      .i_th       (i_th),
      .win_left   (win_left),
      .win_right  (win_right),
      .win_up     (win_up),
      .win_down   (win_down),
      .char_idx   (char_idx),
      .char_up    (char_up),
      .char_down  (char_down),
      .char_left  (char_left),
      .char_right (char_right),
      .char_valid (char_valid)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_box(input string tag);
      logic [48:0] e;
      e = exp_q.pop_front();
      check({tag, ".valid"}, 32'(char_valid), 32'(e[48]));
      check({tag, ".up"},    32'(char_up),    32'(e[47:36]));
      check({tag, ".down"},  32'(char_down),  32'(e[35:24]));
      check({tag, ".left"},  32'(char_left),  32'(e[23:12]));
      check({tag, ".right"}, 32'(char_right), 32'(e[11:0]));
   endtask

   // Bars at x=100..109 and 120..129 on rows 60..110; modes add a narrow bar,
   // a sparse noise row, or a third bar further right.
   function automatic logic stroke(int mode, int x, int y);
      logic s;
      s = 1'b0;
      if (y >= 60 && y <= 110) begin
         if ((x >= 100 && x <= 109) || (x >= 120 && x <= 129)) s = 1'b1;
         if (mode == 1 && x >= 95 && x <= 97)   s = 1'b1;
         if (mode == 2 && x >= 150 && x <= 159) s = 1'b1;
      end
      if (mode == 1 && y == 55 && (x == 135 || x == 137)) s = 1'b1;
      return s;
   endfunction

   task automatic start_frame(input int mode, input int idx, input int wl, input int wr);
      win_left  = 12'(wl);
      win_right = 12'(wr);
      win_up    = 12'd50;
      win_down  = 12'd120;
      char_idx  = 3'(idx);
      step();
      i_vs = 1'b1;
      repeat (3) step();
      for (int y = 50; y <= 120; y++) begin
         for (int x = 85; x <= 165; x++) begin
            i_de = 1'b1;
            i_x  = 12'(x);
            i_y  = 12'(y);
            i_th = stroke(mode, x, y);
            step();
         end
         i_de = 1'b0;
         i_th = 1'b0;
         repeat (4) step();
      end
      repeat (3) step();
      i_vs = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int mode, input int idx, input int wl,
                            input int wr, input logic ev, input int eu, input int ed,
                            input int el, input int er);
      int n;
      n = (wr < wl) ? 0 : ((wr - wl + 1 > 256) ? 256 : wr - wl + 1);
      start_frame(mode, idx, wl, wr);
      repeat (n + 2) step();
      exp_q.push_back(model_box);
      check_box({tag, ".pre"});
      step();
      if (ev) model_box = {1'b1, 12'(eu), 12'(ed), 12'(el), 12'(er)};
      else    model_box[48] = 1'b0;
      exp_q.push_back(model_box);
      check_box({tag, ".post"});
      repeat (260) step();
   endtask

   initial begin
      rst_n = 1'b0;
      i_vs = 1'b0; i_de = 1'b0; i_th = 1'b0; i_x = '0; i_y = '0;
      win_left = '0; win_right = '0; win_up = '0; win_down = '0; char_idx = '0;
      model_box = '0;
      repeat (3) step();
      exp_q.push_back(model_box);
      check_box("reset");
      rst_n = 1'b1;
      repeat (2) step();

      run_frame("two_bars_idx1", 0, 1, 90, 200, 1'b1, 60, 110, 120, 129);
      run_frame("narrow_noise",  1, 0, 90, 200, 1'b1, 60, 110, 100, 109);
      run_frame("idx5_absent",   0, 5, 90, 200, 1'b0, 0, 0, 0, 0);
      run_frame("idx1_again",    0, 1, 90, 200, 1'b1, 60, 110, 120, 129);
      run_frame("inverted_win",  0, 0, 200, 90, 1'b0, 0, 0, 0, 0);

      // Reset while column 40 is about to be read; columns 60..69 still hold a bar.
      start_frame(2, 1, 90, 200);
      repeat (42) step();
      rst_n = 1'b0;
      #1;
      model_box = '0;
      exp_q.push_back(model_box);
      check_box("mid_scan_reset");
      repeat (3) step();
      rst_n = 1'b1;
      repeat (300) step();

      run_frame("after_reset_idx2", 0, 2, 90, 200, 1'b0, 0, 0, 0, 0);
      run_frame("after_reset_idx1", 0, 1, 90, 200, 1'b1, 60, 110, 120, 129);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
